// File: rtl/endgame_stats_chars.sv
// Character source for the end-of-game stats panel: labels plus two 5-digit decimal
// fields, with binary-to-BCD conversion done serially after a start request.
module endgame_stats_chars #(
    parameter int unsigned ROW_MOVES = 8,
    parameter int unsigned ROW_TIME  = 10,
    parameter int unsigned COL_TXT   = 8
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] moves,
    input  logic [13:0] time_s,
    input  logic [9:0]  char_yx,
    output logic [6:0]  char_code,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] RowMoves = 5'(ROW_MOVES);
    localparam logic [4:0] RowTime  = 5'(ROW_TIME);
    localparam logic [4:0] ColTxt   = 5'(COL_TXT);
    localparam logic [4:0] MaxX     = 5'd27;
    localparam logic [4:0] MaxY     = 5'd16;
    localparam logic [6:0] Space    = 7'h20;

    typedef enum logic [2:0] {
        StIdle,
        StConvM,
        StStoreM,
        StConvT,
        StStoreT,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [13:0] shift_q, shift_d;
    logic [13:0] time_q, time_d;
    logic [19:0] bcd_q, bcd_d;
    logic [19:0] moves_bcd_q, moves_bcd_d;
    logic [19:0] time_bcd_q, time_bcd_d;
    logic [6:0]  char_code_q, char_code_d;
    logic [19:0] bcd_step;

    logic [4:0]  cell_x, cell_y, col_off;

    // One double-dabble iteration: add 3 to every digit >= 5, then shift in the next bit.
    function automatic logic [19:0] dabble_step(input logic [19:0] v, input logic b);
        logic [19:0] r;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] >= 4'd5) ? v[4*i +: 4] + 4'd3 : v[4*i +: 4];
        end
        return {r[18:0], b};
    endfunction

    function automatic logic [6:0] label_char(input logic is_time, input logic [2:0] idx);
        logic [6:0] c;
        c = Space;
        case ({is_time, idx})
            4'b0_000: c = 7'h4D; // M
            4'b0_001: c = 7'h4F; // O
            4'b0_010: c = 7'h56; // V
            4'b0_011: c = 7'h45; // E
            4'b0_100: c = 7'h53; // S
            4'b0_101: c = 7'h3A; // :
            4'b1_000: c = 7'h54; // T
            4'b1_001: c = 7'h49; // I
            4'b1_010: c = 7'h4D; // M
            4'b1_011: c = 7'h45; // E
            4'b1_100: c = 7'h3A; // :
            default:  c = Space;
        endcase
        return c;
    endfunction

    // Cell content for one stats row; off is the column relative to the label start.
    function automatic logic [6:0] row_char(input logic is_time, input logic [4:0] off,
                                            input logic [19:0] digs);
        logic [6:0] c;
        logic [3:0] d;
        logic       blank;
        c     = Space;
        d     = 4'd0;
        blank = 1'b0;
        if (off < 5'd6) begin
            c = label_char(is_time, off[2:0]);
        end else if (off >= 5'd7 && off <= 5'd11) begin
            case (off)
                5'd7: begin
                    d     = digs[19:16];
                    blank = (digs[19:16] == 4'd0);
                end
                5'd8: begin
                    d     = digs[15:12];
                    blank = (digs[19:12] == 8'd0);
                end
                5'd9: begin
                    d     = digs[11:8];
                    blank = (digs[19:8] == 12'd0);
                end
                5'd10: begin
                    d     = digs[7:4];
                    blank = (digs[19:4] == 16'd0);
                end
                default: begin
                    d     = digs[3:0];
                    blank = 1'b0;
                end
            endcase
            c = blank ? Space : {3'b011, d};
        end
        return c;
    endfunction

    assign bcd_step = dabble_step(bcd_q, shift_q[13]);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        time_d      = time_q;
        bcd_d       = bcd_q;
        moves_bcd_d = moves_bcd_q;
        time_bcd_d  = time_bcd_q;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StConvM;
                    shift_d = moves;
                    time_d  = time_s;
                    bcd_d   = '0;
                    cnt_d   = '0;
                end
            end
            StConvM, StConvT: begin
                busy    = 1'b1;
                bcd_d   = bcd_step;
                shift_d = {shift_q[12:0], 1'b0};
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    cnt_d   = '0;
                    state_d = (state_q == StConvM) ? StStoreM : StStoreT;
                end
            end
            StStoreM: begin
                busy        = 1'b1;
                moves_bcd_d = bcd_q;
                shift_d     = time_q;
                bcd_d       = '0;
                state_d     = StConvT;
            end
            StStoreT: begin
                busy       = 1'b1;
                time_bcd_d = bcd_q;
                state_d    = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign cell_y  = char_yx[9:5];
    assign cell_x  = char_yx[4:0];
    assign col_off = cell_x - ColTxt;

    always_comb begin
        char_code_d = Space;
        if (cell_x <= MaxX && cell_y <= MaxY && cell_x >= ColTxt) begin
            if (cell_y == RowMoves) begin
                char_code_d = row_char(1'b0, col_off, moves_bcd_q);
            end else if (cell_y == RowTime) begin
                char_code_d = row_char(1'b1, col_off, time_bcd_q);
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shift_q     <= '0;
            time_q      <= '0;
            bcd_q       <= '0;
            moves_bcd_q <= '0;
            time_bcd_q  <= '0;
            char_code_q <= Space;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            time_q      <= time_d;
            bcd_q       <= bcd_d;
            moves_bcd_q <= moves_bcd_d;
            time_bcd_q  <= time_bcd_d;
            char_code_q <= char_code_d;
        end
    end

    assign char_code = char_code_q;

endmodule
